// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register write arbiter.
package shared_reg_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   // Index reached by stepping 'offset' places from 'base' around a ring of n entries.
   function automatic int rotate_idx(input int base, input int offset, input int n);
      return (base + offset) % n;
   endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Rotated priority encoder: first set bit of 'eligible' searching ptr, ptr+1, ... mod N_REQ.
module shared_reg_arbiter_rr_pick
   import shared_reg_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] eligible,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] winner
);

   // rotated[k] is the request sitting k places after the pointer
   logic [N_REQ-1:0] rotated;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rotated[gi] = eligible[IDX_W'(rotate_idx(int'(ptr), gi, N_REQ))];
   end

   always_comb begin
      winner = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            winner = IDX_W'(rotate_idx(int'(ptr), k, N_REQ));
         end
      end
   end

   assign any = |eligible;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of one shared register with true/complement outputs.
module shared_reg_arbiter
   import shared_reg_arbiter_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int IDX_W  = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] data,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        ack,
   output logic [DATA_W-1:0]       q,
   output logic [DATA_W-1:0]       qbar,
   output logic                    q_valid,
   output logic [IDX_W-1:0]        last_src
);

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  ptr_reg, ptr_next;
   logic [IDX_W-1:0]  win_idx_reg, win_idx_next;
   logic [N_REQ-1:0]  gnt_reg, gnt_next;
   logic [N_REQ-1:0]  ack_reg, ack_next;
   logic [DATA_W-1:0] q_reg, q_next;
   logic [DATA_W-1:0] qbar_reg, qbar_next;
   logic              q_valid_reg, q_valid_next;
   logic [IDX_W-1:0]  last_src_reg, last_src_next;

   logic [DATA_W-1:0] data_arr [N_REQ];
   logic [N_REQ-1:0]  eligible;
   logic              pick_any;
   logic [IDX_W-1:0]  pick_winner;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = data[gi*DATA_W +: DATA_W];
   end

   // A requester in its ack cycle is masked so a late req drop cannot win again
   assign eligible = req & ~ack_reg;

   shared_reg_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .eligible (eligible),
      .ptr      (ptr_reg),
      .any      (pick_any),
      .winner   (pick_winner)
   );

   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      win_idx_next  = win_idx_reg;
      gnt_next      = '0;
      ack_next      = '0;
      q_next        = q_reg;
      qbar_next     = qbar_reg;
      q_valid_next  = q_valid_reg;
      last_src_next = last_src_reg;
      case (state_reg)
         IDLE: begin
            if (pick_any) begin
               gnt_next     = N_REQ'(1) << pick_winner;
               win_idx_next = pick_winner;
               state_next   = WRITE;
            end
         end
         WRITE: begin
            q_next        = data_arr[win_idx_reg];
            qbar_next     = ~data_arr[win_idx_reg];
            ack_next      = N_REQ'(1) << win_idx_reg;
            last_src_next = win_idx_reg;
            q_valid_next  = 1'b1;
            ptr_next      = IDX_W'(rotate_idx(int'(win_idx_reg), 1, N_REQ));
            state_next    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         ptr_reg      <= '0;
         win_idx_reg  <= '0;
         gnt_reg      <= '0;
         ack_reg      <= '0;
         q_reg        <= '0;
         qbar_reg     <= '0;
         q_valid_reg  <= 1'b0;
         last_src_reg <= '0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         win_idx_reg  <= win_idx_next;
         gnt_reg      <= gnt_next;
         ack_reg      <= ack_next;
         q_reg        <= q_next;
         qbar_reg     <= qbar_next;
         q_valid_reg  <= q_valid_next;
         last_src_reg <= last_src_next;
      end
   end

   assign gnt      = gnt_reg;
   assign ack      = ack_reg;
   assign q        = q_reg;
   assign qbar     = qbar_reg;
   assign q_valid  = q_valid_reg;
   assign last_src = last_src_reg;

endmodule
